// File: rtl/byte_serial_adder_pkg.sv
// rtl/byte_serial_adder_pkg.sv - shared types and constants for the byte-serial adder
`timescale 1ns/1ps
package byte_serial_adder_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Width of a counter that must hold 0..n-1; never narrower than one bit.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) begin
         r++;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/byte_serial_adder_cla8_core.sv
// rtl/byte_serial_adder_cla8_core.sv - combinational 8-bit carry-lookahead adder core
`timescale 1ns/1ps
module cla8_core
   import byte_serial_adder_pkg::*;
(
   input  logic [BYTE_W-1:0] a,
   input  logic [BYTE_W-1:0] b,
   input  logic              ci,
   output logic [BYTE_W-1:0] s,
   output logic              co
);

   // Returns {group_g, group_p, c3, c2, c1} for a 4-bit lookahead block.
   function automatic logic [4:0] la4(input logic [3:0] g, input logic [3:0] p, input logic c0);
      logic c1, c2, c3, gg, pg;
      c1 = g[0] | (p[0] & c0);
      c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
      gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      pg = &p;
      return {gg, pg, c3, c2, c1};
   endfunction

   logic [BYTE_W-1:0] g;
   logic [BYTE_W-1:0] p;
   logic [BYTE_W:0]   c;
   logic [4:0]        lo;
   logic [4:0]        hi;

   assign g = a & b;
   assign p = a ^ b;

   assign lo = la4(g[3:0], p[3:0], ci);
   // Upper nibble carry-in comes from the lower group terms, not from a ripple.
   assign c[0] = ci;
   assign c[3:1] = {lo[2], lo[1], lo[0]};
   assign c[4] = lo[4] | (lo[3] & ci);

   assign hi = la4(g[7:4], p[7:4], c[4]);
   assign c[7:5] = {hi[2], hi[1], hi[0]};
   assign c[8] = hi[4] | (hi[3] & lo[4]) | (hi[3] & lo[3] & ci);

   assign s  = p ^ c[BYTE_W-1:0];
   assign co = c[BYTE_W];

endmodule

// File: rtl/byte_serial_adder.sv
// rtl/byte_serial_adder.sv - byte-serial wide adder, LSB first; optional SUBTRACT_EN adds the sub port
`timescale 1ns/1ps
module byte_serial_adder
   import byte_serial_adder_pkg::*;
#(
   parameter  int NBYTES = 4,
   localparam int W      = 8 * NBYTES
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
`ifdef SUBTRACT_EN
   input  logic         sub,
`endif
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         ovf
);

   localparam int IDX_W = clog2(NBYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

   state_e            state_q;
   logic [W-1:0]      a_q;
   logic [W-1:0]      b_q;
   logic [W-1:0]      sum_q;
   logic [W-1:0]      sum_d;
   logic              carry_q;
   logic              cout_q;
   logic              ovf_q;
   logic              a_msb_q;
   logic              b_msb_q;
   logic [IDX_W-1:0]  idx_q;

   logic [W-1:0]      b_eff;
   logic              ci_eff;
   logic [BYTE_W-1:0] core_s;
   logic              core_co;
   logic              last_byte;

`ifdef SUBTRACT_EN
   assign b_eff  = sub ? ~b : b;
   assign ci_eff = sub | cin;
`else
   assign b_eff  = b;
   assign ci_eff = cin;
`endif

   cla8_core u_core (
      .a  (a_q[BYTE_W-1:0]),
      .b  (b_q[BYTE_W-1:0]),
      .ci (carry_q),
      .s  (core_s),
      .co (core_co)
   );

   assign last_byte = (idx_q == LAST_IDX);
   assign sum_d     = {core_s, sum_q[W-1:BYTE_W]};

   // MSBs of A and effective B are kept so overflow needs no wide compare at the end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         idx_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= a;
                  b_q     <= b_eff;
                  carry_q <= ci_eff;
                  a_msb_q <= a[W-1];
                  b_msb_q <= b_eff[W-1];
                  idx_q   <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               sum_q   <= sum_d;
               carry_q <= core_co;
               a_q     <= a_q >> BYTE_W;
               b_q     <= b_q >> BYTE_W;
               idx_q   <= idx_q + IDX_W'(1);
               if (last_byte) begin
                  cout_q  <= core_co;
                  ovf_q   <= (a_msb_q == b_msb_q) && (core_s[BYTE_W-1] != a_msb_q);
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_byte_serial_adder.sv
// tb/tb_byte_serial_adder.sv - self-checking bench for byte_serial_adder (SUBTRACT_EN aware)
`timescale 1ns/1ps
module tb_byte_serial_adder;

   localparam int NBYTES = 4;
   localparam int W      = 8 * NBYTES;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   byte_serial_adder #(.NBYTES(NBYTES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef SUBTRACT_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   typedef struct {
      logic [W-1:0] va;
      logic [W-1:0] vb;
      logic         vcin;
      logic         vsub;
      logic [W-1:0] esum;
      logic         ecout;
      logic         eovf;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference: whole-word arithmetic straight from the add/subtract rules.
   function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic mc, input logic ms);
      logic [W-1:0] be;
      logic         ce;
      logic [W:0]   t;
      logic         o;
      be = ms ? ~mb : mb;
      ce = ms ? 1'b1 : mc;
      t  = {1'b0, ma} + {1'b0, be} + {{W{1'b0}}, ce};
      o  = (ma[W-1] == be[W-1]) && (t[W-1] != ma[W-1]);
      return {o, t};
   endfunction

   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_in, input logic tc,
                         input logic ts, input int hold,
                         output logic [W-1:0] rs, output logic rc, output logic ro, output int lat);
      int g;
      @(negedge clk);
      g = 0;
      while (!in_ready && g < 20) begin
         @(negedge clk);
         g++;
      end
      a = ta; b = tb_in; cin = tc; sub = ts; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      rs = sum; rc = cout; ro = ovf;
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1;
         a = ~a;
         @(posedge clk);
         #1 in_valid = 1'b0;
         chk("hold_sum", sum, rs);
         chk("hold_cout", cout, rc);
         chk("hold_ovf", ovf, ro);
         chk("hold_in_ready", in_ready, 1'b0);
         chk("hold_out_valid", out_valid, 1'b1);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk("post_in_ready", in_ready, 1'b1);
      chk("post_out_valid", out_valid, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t          tbl[$];
      logic [W-1:0]  rs;
      logic          rc, ro;
      int            lat;
      logic [W+1:0]  m;
      logic [W-1:0]  ra, rb;
      logic          rcin, rsub;
      int            acc[$];
      logic [W-1:0]  bres[$];
      logic          bcout[$];
      int            naccept;

      tbl.push_back(vec_t'{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0});
      tbl.push_back(vec_t'{32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0});
      tbl.push_back(vec_t'{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1});
      tbl.push_back(vec_t'{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1});
      tbl.push_back(vec_t'{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0});
      tbl.push_back(vec_t'{32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0});
`ifdef SUBTRACT_EN
      tbl.push_back(vec_t'{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0});
      tbl.push_back(vec_t'{32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0});
      tbl.push_back(vec_t'{32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1});
`endif

      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_sum", sum, '0);
      chk("rst_cout", cout, 1'b0);
      chk("rst_ovf", ovf, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         run_op(tbl[i].va, tbl[i].vb, tbl[i].vcin, tbl[i].vsub, (i == 1) ? 3 : 0, rs, rc, ro, lat);
         chk($sformatf("vec%0d_sum", i), rs, tbl[i].esum);
         chk($sformatf("vec%0d_cout", i), rc, tbl[i].ecout);
         chk($sformatf("vec%0d_ovf", i), ro, tbl[i].eovf);
         chk($sformatf("vec%0d_latency", i), lat, NBYTES);
      end

      // Reset pulse during the second RUN cycle discards the operation.
      @(negedge clk);
      a = 32'h11111111; b = 32'h11111111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrun_rst_out_valid", out_valid, 1'b0);
      chk("midrun_rst_sum", sum, '0);
      chk("midrun_rst_in_ready", in_ready, 1'b1);
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk("rst_ignores_in_valid", in_ready, 1'b1);
      chk("rst_hold_sum", sum, '0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(32'd3, 32'd4, 1'b0, 1'b0, 0, rs, rc, ro, lat);
      chk("after_rst_sum", rs, 32'd7);
      chk("after_rst_latency", lat, NBYTES);

      // Back-to-back with in_valid held high and out_ready held high.
      @(negedge clk);
      a = 32'hDEADBEEF; b = 32'h01234567; cin = 1'b1; sub = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1; naccept = 0;
      for (int k = 0; k < 40 && bres.size() < 2; k++) begin
         if (out_valid) begin
            bres.push_back(sum);
            bcout.push_back(cout);
         end
         if (in_ready && in_valid) begin
            acc.push_back(k);
            naccept++;
         end else if (naccept == 1) begin
            a = 32'hF0000001; b = 32'h10000000; cin = 1'b0;
         end else if (naccept == 2) begin
            in_valid = 1'b0;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("b2b_accepts", acc.size(), 2);
      chk("b2b_results", bres.size(), 2);
      if (acc.size() == 2) chk("b2b_interval", acc[1] - acc[0], NBYTES + 2);
      if (bres.size() == 2) begin
         m = model(32'hDEADBEEF, 32'h01234567, 1'b1, 1'b0);
         chk("b2b_sum0", bres[0], m[W-1:0]);
         chk("b2b_cout0", bcout[0], m[W]);
         m = model(32'hF0000001, 32'h10000000, 1'b0, 1'b0);
         chk("b2b_sum1", bres[1], m[W-1:0]);
         chk("b2b_cout1", bcout[1], m[W]);
      end
      repeat (2) @(posedge clk);

      for (int r = 0; r < 20; r++) begin
         ra = $urandom;
         rb = $urandom;
         if (r % 5 == 0) rb = ~ra;
         rcin = 1'($urandom_range(0, 1));
`ifdef SUBTRACT_EN
         rsub = 1'($urandom_range(0, 1));
`else
         rsub = 1'b0;
`endif
         m = model(ra, rb, rcin, rsub);
         run_op(ra, rb, rcin, rsub, int'($urandom_range(0, 2)), rs, rc, ro, lat);
         chk($sformatf("rnd%0d_sum", r), rs, m[W-1:0]);
         chk($sformatf("rnd%0d_cout", r), rc, m[W]);
         chk($sformatf("rnd%0d_ovf", r), ro, m[W+1]);
         chk($sformatf("rnd%0d_latency", r), lat, NBYTES);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/byte_serial_adder.md
# byte_serial_adder

Multi-cycle wide adder that splits NBYTES-byte operands into bytes and adds them least-significant byte first, one byte per clock. It uses a single combinational 8-bit carry-lookahead core and a registered inter-byte carry. It sits directly upstream of result consumers and wraps the 8-bit CLA datapath. Operands arrive through a valid/ready handshake; each result is held on a valid/ready output until it is taken.

## Interface
- NBYTES, 4, operand width in bytes; legal range 2..16; W = 8*NBYTES
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand transfer request
- in_ready  out  1  block can accept operands; high only in IDLE
- a  in  W  operand A
- b  in  W  operand B
- cin  in  1  carry into byte 0
- sub  in  1  subtract select; present only with SUBTRACT_EN
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- sum  out  W  result
- cout  out  1  carry out of the MSB
- ovf  out  1  two's-complement overflow

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - RUN: one byte per cycle.
  - DONE: out_valid=1.
- IDLE→RUN on in_valid&&in_ready:
  - latch a and b into shift registers (b inverted if sub);
  - latch the carry register from cin (forced to 1 if sub);
  - set byte index=0.
- RUN, each cycle:
  - the core adds the low byte of each operand register plus the carry register;
  - the sum byte shifts into the MSB end of the result register;
  - the core's carry-out loads the carry register;
  - the operand registers shift right by 8;
  - the index increments.
- RUN→DONE when the index reaches NBYTES-1 and that byte completes.
  - cout = final carry.
  - ovf = (A[W-1]==B'[W-1]) && (sum[W-1]!=A[W-1]), where B' is the effective (possibly inverted) B.
- DONE→IDLE on out_ready. sum, cout and ovf hold stable while out_valid=1 and out_ready=0.
- in_valid while not in IDLE is ignored; no operand is lost because in_ready=0.
- Arithmetic is modulo 2^W; cout is the true W+1th bit.
- Reset values:
  - state=IDLE, in_ready=1;
  - out_valid=0, sum=0, cout=0, ovf=0;
  - index=0, carry register=0.
- Transfers while rst_n=0 are ignored.
- Reset asserted mid-RUN or mid-DONE aborts the operation immediately; the partial result is discarded.

## Timing
- Acceptance edge T0. Bytes are processed on edges T1..TNBYTES. out_valid rises after edge TNBYTES.
- Latency is NBYTES cycles from accept to out_valid.
- Minimum initiation interval is NBYTES+2 cycles: accept, NBYTES RUN cycles, one DONE cycle with out_ready=1, then IDLE.
- in_ready and out_valid are decoded from registered state only; there is no combinational path from in_valid or out_ready to any output.
- Critical path: one 8-bit CLA plus the carry register setup, independent of NBYTES.

## Configuration
- SUBTRACT_EN defined:
  - the sub port exists;
  - sub=1 computes A-B-(~cin)... simplified rule: sub=1 forces carry-in 1 and inverts B, so the result is A-B and cin is ignored;
  - cout=1 means no borrow.
- SUBTRACT_EN undefined: the sub port is absent, B is never inverted, and the block is add-only.

## Structure
- Shared package byte_serial_adder_pkg holds:
  - the FSM state enum (IDLE, RUN, DONE);
  - the byte-width constant BYTE_W=8;
  - the index-width function clog2(NBYTES).
- One sub-module, cla8_core: combinational 8-bit generate/propagate carry-lookahead adder with ports a[7:0], b[7:0], ci, s[7:0], co. It is instantiated once.

## Test plan
- NBYTES=4, a=0xFFFFFFFF, b=0x00000001, cin=0 → sum=0x00000000, cout=1, ovf=0, out_valid exactly 4 cycles after accept.
- a=0x12345678, b=0x11111111, cin=1 → sum=0x2345678A, cout=0. a=0x7FFFFFFF, b=0x00000001 → sum=0x80000000, ovf=1, cout=0.
- Hold out_ready=0 for 3 cycles after out_valid → sum, cout, ovf stable and in_ready=0 throughout; in_valid pulses in that window are not accepted.
- Pulse rst_n low on the second RUN cycle → out_valid=0, sum=0 during reset. After release, in_ready=1 and a new operation 3+4 gives 0x00000007.
- SUBTRACT_EN: a=5, b=7, sub=1 → sum=0xFFFFFFFE, cout=0. a=7, b=5, sub=1 → sum=0x00000002, cout=1.
- Back-to-back operations with in_valid held high and out_ready=1 → second accept occurs NBYTES+2 cycles after the first, and both results are correct.
